exec_unit: RTL and testbench



---
 rtl/exec_pkg.sv | 52 +++++
 rtl/exec_iter.sv | 92 +++++++++
 rtl/exec_unit.sv | 166 ++++++++++++++++
 tb/tb_exec_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcodes, FSM state type and helpers for exec_unit
// Optional feature macro: EXEC_MUL_EN (shift-add multiplier on opcode 100).
// Contents:
//   ADDR_W      register-file address width
//   OP_*        ALUOP encodings
//   state_t     control FSM states IDLE/RUN/FIN
//   iter_mode_t iterative datapath modes
//   op_is_iter  true when an opcode needs the iterative datapath
package exec_pkg;

  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_SLL = 2'd1,
    IT_SRL = 2'd2,
    IT_SRA = 2'd3
  } iter_mode_t;

  // A shift by zero has nothing to iterate over, so it completes as a
  // single-cycle forward of A.
  function automatic logic op_is_iter(input logic [2:0] op, input logic shamt_zero);
    logic r;
    r = 1'b0;
    case (op)
`ifdef EXEC_MUL_EN
      OP_MUL:                 r = 1'b1;
`else
      OP_MUL:                 r = 1'b0;
`endif
      OP_SLL, OP_SRL, OP_SRA: r = !shamt_zero;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_iter.sv
// rtl/exec_iter.sv - iterative shift / shift-add multiply datapath
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and mode (one cycle, while not running)
//   run         perform one iteration this cycle
//   mode        iterative operation selected at start
//   a, b        operands; b[CNTW-1:0] is the shift amount for shifts
//   res_next    accumulator value after this cycle's iteration
//   last        this cycle performs the final iteration
module exec_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_next,
  output logic             last
);

  iter_mode_t       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CNTW-1:0]  term_q, term_d;
  logic [WIDTH-1:0] acc_step;

  // One iteration: multiply adds the shifted multiplicand when the current
  // multiplier bit is set; shifts move the accumulator by one position.
  always_comb begin
    acc_step = acc_q;
    case (mode_q)
      IT_MUL:  acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      IT_SLL:  acc_step = acc_q << 1;
      IT_SRL:  acc_step = acc_q >> 1;
      IT_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    if (start) begin
      mode_d   = mode;
      acc_d    = (mode == IT_MUL) ? '0 : a;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      // Terminal count is the index of the final iteration.
      term_d   = (mode == IT_MUL) ? CNTW'(WIDTH - 1) : (b[CNTW-1:0] - CNTW'(1));
    end else if (run) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= IT_MUL;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      term_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      term_q   <= term_d;
    end
  end

  assign res_next = acc_step;
  assign last     = run && (cnt_q == term_q);

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - multi-cycle execution unit feeding the register-file write port
// Optional feature macro: EXEC_MUL_EN (when undefined, opcode 100 returns 0 in one cycle).
// Ports:
//   CLK, RESET       clock, asynchronous active-low reset
//   START            request, accepted when BUSY=0
//   ALUOP            operation code, latched on acceptance
//   DATA1, DATA2     operands A and B, latched on acceptance
//   DESTADDR         destination register, latched on acceptance
//   BUSY             iterative operation in progress
//   DONE, WRITE      one-cycle result-valid / register-file write strobe
//   RESULT           result, held until the next completion
//   CARRY            carry out of ADD, 0 otherwise
//   ZERO             RESULT == 0
//   INADDRESS        destination register for the write strobe
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        ALUOP,
  input  logic [WIDTH-1:0]  DATA1,
  input  logic [WIDTH-1:0]  DATA2,
  input  logic [ADDR_W-1:0] DESTADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic [WIDTH-1:0]  RESULT,
  output logic              CARRY,
  output logic              ZERO,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] inaddr_q, inaddr_d;
  logic [ADDR_W-1:0] dest_q, dest_d;

  logic              accept;
  logic              take_iter;
  logic              iter_run;
  logic              iter_last;
  logic [WIDTH-1:0]  iter_res;
  iter_mode_t        iter_mode;
  logic [WIDTH-1:0]  single_res;
  logic              single_carry;
  logic [WIDTH:0]    add_full;

  // FIN accepts a new request, so back-to-back operations need no idle cycle.
  assign accept    = START && (state_q != RUN);
  assign take_iter = accept && op_is_iter(ALUOP, DATA2[CNTW-1:0] == '0);
  assign iter_run  = (state_q == RUN);

  always_comb begin
    add_full     = {1'b0, DATA1} + {1'b0, DATA2};
    single_res   = '0;
    single_carry = 1'b0;
    case (ALUOP)
      OP_FWD: single_res = DATA1;
      OP_ADD: begin
        single_res   = add_full[WIDTH-1:0];
        single_carry = add_full[WIDTH];
      end
      OP_AND: single_res = DATA1 & DATA2;
      OP_OR:  single_res = DATA1 | DATA2;
      // Only reached as single-cycle when the shift amount is zero.
      OP_SLL, OP_SRL, OP_SRA: single_res = DATA1;
      // Multiplier compiled out: opcode 100 yields 0.
      default: single_res = '0;
    endcase
  end

  always_comb begin
    iter_mode = IT_MUL;
    case (ALUOP)
      OP_SLL:  iter_mode = IT_SLL;
      OP_SRL:  iter_mode = IT_SRL;
      OP_SRA:  iter_mode = IT_SRA;
      default: iter_mode = IT_MUL;
    endcase
  end

  exec_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter (
    .clk      (CLK),
    .rst_n    (RESET),
    .start    (take_iter),
    .run      (iter_run),
    .mode     (iter_mode),
    .a        (DATA1),
    .b        (DATA2),
    .res_next (iter_res),
    .last     (iter_last)
  );

  // Write-back registers change only on the edge entering FIN, so they stay
  // stable for the whole DONE cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    inaddr_d = inaddr_q;
    dest_d   = dest_q;
    case (state_q)
      RUN: begin
        if (iter_last) begin
          state_d  = FIN;
          result_d = iter_res;
          carry_d  = 1'b0;
          zero_d   = (iter_res == '0);
          inaddr_d = dest_q;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          dest_d = DESTADDR;
          if (take_iter) begin
            state_d = RUN;
          end else begin
            state_d  = FIN;
            result_d = single_res;
            carry_d  = single_carry;
            zero_d   = (single_res == '0);
            inaddr_d = DESTADDR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      inaddr_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      inaddr_q <= inaddr_d;
      dest_q   <= dest_d;
    end
  end

  assign BUSY      = (state_q == RUN);
  assign DONE      = (state_q == FIN);
  assign WRITE     = (state_q == FIN);
  assign RESULT    = result_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign INADDRESS = inaddr_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking testbench for exec_unit
module tb_exec_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] ALUOP;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] DESTADDR;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       WRITE;
  logic [2:0] INADDRESS;

  int n_checks = 0;
  int n_fail   = 0;

  exec_unit #(.WIDTH(8), .CNTW(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ALUOP     (ALUOP),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .DESTADDR  (DESTADDR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .CARRY     (CARRY),
    .ZERO      (ZERO),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model from the opcode table, using integer arithmetic.
  function automatic int model_res(int op, int a, int b);
    int n;
    int s;
    n = b % 8;
    case (op)
      0: return a;
      1: return (a + b) % 256;
      2: return a & b;
      3: return a | b;
`ifdef EXEC_MUL_EN
      4: return (a * b) % 256;
`else
      4: return 0;
`endif
      5: return (a << n) % 256;
      6: return a >> n;
      default: begin
        s = (a >= 128) ? a - 256 : a;
        return (s >>> n) & 255;
      end
    endcase
  endfunction

  function automatic int model_carry(int op, int a, int b);
    return (op == 1 && (a + b) > 255) ? 1 : 0;
  endfunction

  // Cycles from driving START to DONE sampled high.
  function automatic int model_lat(int op, int b);
`ifdef EXEC_MUL_EN
    if (op == 4) return 9;
`endif
    if (op >= 5) return 1 + (b % 8);
    return 1;
  endfunction

  // Issues one operation, scrambles the operands right after acceptance and
  // reports what was observed on the DONE cycle.
  task automatic do_op(input int op, input int a, input int b, input int d,
                       output int lat, output int busy_cnt, output int res,
                       output int c, output int z, output int addr, output int w,
                       output int timeout);
    @(negedge CLK);
    START    = 1'b1;
    ALUOP    = 3'(op);
    DATA1    = 8'(a);
    DATA2    = 8'(b);
    DESTADDR = 3'(d);
    @(posedge CLK);
    #1;
    START = 1'b0;
    DATA1 = 8'($urandom);
    DATA2 = 8'($urandom);
    lat      = 1;
    busy_cnt = 0;
    timeout  = 0;
    while (!DONE) begin
      if (BUSY) busy_cnt++;
      @(posedge CLK);
      #1;
      lat++;
      if (lat > 40) begin
        timeout = 1;
        break;
      end
    end
    res  = int'(RESULT);
    c    = int'(CARRY);
    z    = int'(ZERO);
    addr = int'(INADDRESS);
    w    = int'(WRITE);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    START = 1'b0;
    ALUOP = 3'd0;
    DATA1 = 8'd0;
    DATA2 = 8'd0;
    DESTADDR = 3'd0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({BUSY, DONE, WRITE, CARRY, ZERO} !== 5'b00001 || RESULT !== 8'h00 || INADDRESS !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b write=%b carry=%b zero=%b result=%h inaddr=%0d, required 0 0 0 0 1 00 0",
               BUSY, DONE, WRITE, CARRY, ZERO, RESULT, INADDRESS);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_add_and_back_to_back();
    int lat, bc, res, c, z, addr, w, to;
    do_op(1, 'hF0, 'h20, 5, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 1 || res != 'h10 || c != 1 || z != 0 || addr != 5 || w != 1) begin
      n_fail++;
      $display("FAIL add_f0_20: lat=%0d res=%h carry=%0d zero=%0d addr=%0d write=%0d, required 1 10 1 0 5 1",
               lat, res, c, z, addr, w);
    end
    do_op(2, 'h0F, 'hF0, 2, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 1 || res != 0 || c != 0 || z != 1 || addr != 2 || w != 1) begin
      n_fail++;
      $display("FAIL and_back_to_back: lat=%0d res=%h carry=%0d zero=%0d addr=%0d write=%0d, required 1 00 0 1 2 1",
               lat, res, c, z, addr, w);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (DONE !== 1'b0 || WRITE !== 1'b0 || RESULT !== 8'h00 || ZERO !== 1'b1 || INADDRESS !== 3'd2) begin
      n_fail++;
      $display("FAIL hold_after_done: done=%b write=%b result=%h zero=%b inaddr=%0d, required 0 0 00 1 2",
               DONE, WRITE, RESULT, ZERO, INADDRESS);
    end
  endtask

  task automatic test_mul();
    int lat, bc, res, c, z, addr, w, to;
    do_op(4, 13, 11, 3, lat, bc, res, c, z, addr, w, to);
`ifdef EXEC_MUL_EN
    n_checks++;
    if (to != 0 || lat != 9 || bc != 8 || res != 'h8F || c != 0 || z != 0 || addr != 3) begin
      n_fail++;
      $display("FAIL mul_13_11: lat=%0d busy=%0d res=%h carry=%0d zero=%0d addr=%0d, required 9 8 8f 0 0 3",
               lat, bc, res, c, z, addr);
    end
`else
    n_checks++;
    if (to != 0 || lat != 1 || bc != 0 || res != 0 || z != 1 || addr != 3) begin
      n_fail++;
      $display("FAIL mul_disabled: lat=%0d busy=%0d res=%h zero=%0d addr=%0d, required 1 0 00 1 3",
               lat, bc, res, z, addr);
    end
`endif
  endtask

  task automatic test_shifts();
    int lat, bc, res, c, z, addr, w, to;
    do_op(7, 'h90, 3, 6, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 4 || bc != 3 || res != 'hF2 || z != 0 || addr != 6) begin
      n_fail++;
      $display("FAIL sra_90_3: lat=%0d busy=%0d res=%h zero=%0d addr=%0d, required 4 3 f2 0 6",
               lat, bc, res, z, addr);
    end
    do_op(6, 'h90, 3, 1, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 4 || bc != 3 || res != 'h12 || addr != 1) begin
      n_fail++;
      $display("FAIL srl_90_3: lat=%0d busy=%0d res=%h addr=%0d, required 4 3 12 1", lat, bc, res, addr);
    end
    do_op(5, 'hA7, 'hF8, 4, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 1 || bc != 0 || res != 'hA7 || z != 0 || addr != 4) begin
      n_fail++;
      $display("FAIL sll_by_0: lat=%0d busy=%0d res=%h zero=%0d addr=%0d, required 1 0 a7 0 4",
               lat, bc, res, z, addr);
    end
    do_op(5, 'h01, 7, 0, lat, bc, res, c, z, addr, w, to);
    n_checks++;
    if (to != 0 || lat != 8 || bc != 7 || res != 'h80) begin
      n_fail++;
      $display("FAIL sll_by_7: lat=%0d busy=%0d res=%h, required 8 7 80", lat, bc, res);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int to;
    @(negedge CLK);
    START = 1'b1; ALUOP = 3'd6; DATA1 = 8'h90; DATA2 = 8'd3; DESTADDR = 3'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1; ALUOP = 3'd0; DATA1 = 8'h55; DATA2 = 8'h00; DESTADDR = 3'd2;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    DATA1 = 8'hFF;
    lat = 3;
    to  = 0;
    #1;
    while (!DONE) begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat > 40) begin
        to = 1;
        break;
      end
    end
    n_checks++;
    if (to != 0 || lat != 4 || RESULT !== 8'h12 || INADDRESS !== 3'd7) begin
      n_fail++;
      $display("FAIL start_during_busy: lat=%0d res=%h addr=%0d, required 4 12 7", lat, RESULT, INADDRESS);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (DONE !== 1'b0 || RESULT !== 8'h12) begin
      n_fail++;
      $display("FAIL no_late_accept: done=%b res=%h, required 0 12", DONE, RESULT);
    end
  endtask

  task automatic test_reset_mid_op();
    int write_seen;
    write_seen = 0;
    @(negedge CLK);
    START = 1'b1;
`ifdef EXEC_MUL_EN
    ALUOP = 3'd4; DATA1 = 8'd7; DATA2 = 8'd9;
`else
    ALUOP = 3'd6; DATA1 = 8'hC3; DATA2 = 8'd7;
`endif
    DESTADDR = 3'd6;
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (WRITE) write_seen = 1;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (WRITE) write_seen = 1;
    end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({BUSY, DONE, WRITE, CARRY, ZERO} !== 5'b00001 || RESULT !== 8'h00 || INADDRESS !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b write=%b carry=%b zero=%b result=%h inaddr=%0d, required 0 0 0 0 1 00 0",
               BUSY, DONE, WRITE, CARRY, ZERO, RESULT, INADDRESS);
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (WRITE) write_seen = 1;
    end
    n_checks++;
    if (write_seen != 0) begin
      n_fail++;
      $display("FAIL reset_abort_write: write pulses seen=%0d, required 0", write_seen);
    end
  endtask

  task automatic test_random();
    int lat, bc, res, c, z, addr, w, to;
    int op, a, b, d, er;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      d  = int'($urandom_range(0, 7));
      if (i % 5 == 0) a = 0;
      do_op(op, a, b, d, lat, bc, res, c, z, addr, w, to);
      er = model_res(op, a, b);
      n_checks++;
      if (to != 0 || lat != model_lat(op, b) || bc != model_lat(op, b) - 1 || res != er ||
          c != model_carry(op, a, b) || z != ((er == 0) ? 1 : 0) || addr != d || w != 1) begin
        n_fail++;
        $display("FAIL random_op%0d op=%0d a=%h b=%h: lat=%0d busy=%0d res=%h c=%0d z=%0d addr=%0d w=%0d, required lat=%0d res=%h c=%0d addr=%0d w=1",
                 i, op, a, b, lat, bc, res, c, z, addr, w, model_lat(op, b), er, model_carry(op, a, b), d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_and_back_to_back();
    test_mul();
    test_shifts();
    test_busy_ignore();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
